// File: rtl/vc_test_pkg.sv
// vc_test_pkg: shared definitions for the random-delay tag source and sink
// test harness components.
//   state_e     - source FSM encoding (DELAY / SEND / DONE)
//   LFSR_TAPS   - tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   lfsr_next   - one LFSR step
//   clog2_min1  - width needed to count 0..value-1, never less than 1
package vc_test_pkg;

  typedef enum logic [1:0] {
    DELAY = 2'd0,
    SEND  = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Right-shifting form: taps 16,14,13,11 sit on bits 0,2,3,5 and the
  // feedback bit enters at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 32'd1;
    while ((32'd1 << width) < value) begin
      width = width + 32'd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/vc_test_lfsr16.sv
// vc_test_lfsr16: 16-bit Fibonacci LFSR with advance enable.
//   clk        - clock
//   reset      - asynchronous active-low reset, loads p_seed
//   adv        - advance one step on the next posedge
//   next_value - value the register takes on the next advance
module vc_test_lfsr16
  import vc_test_pkg::*;
#(
  parameter logic [15:0] p_seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [15:0] next_value
);

  logic [15:0] lfsr_r;

  // LFSR state: seed on reset, one step per advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= p_seed;
    end else if (adv) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign next_value = lfsr_next(lfsr_r);

endmodule

// File: rtl/vc_test_rand_delay_tag_source.sv
// vc_test_rand_delay_tag_source: replays the message array m[] in index
// order, stamping a wrapping tag into each message and inserting an
// LFSR-chosen idle gap of 0..p_max_delay cycles before each one.
//   clk      - clock
//   reset    - asynchronous active-low reset
//   num_msgs - number of valid entries in m[] (static after reset)
//   val/rdy  - valid/ready handshake of the outgoing message stream
//   msg      - current message with the tag field substituted
//   done     - all num_msgs messages have been accepted
// m[] has no write port: it is loaded hierarchically while reset is held
// and is deliberately left untouched by reset.
module vc_test_rand_delay_tag_source
  import vc_test_pkg::*;
#(
  parameter int unsigned p_msg_nbits   = 1,
  parameter int unsigned p_num_entries = 1024,
  parameter int unsigned p_idx_nbits   = 10,
  parameter int unsigned p_tag_nbits   = 1,
  parameter int unsigned p_tag_offset  = 0,
  parameter int unsigned p_max_delay   = 0,
  parameter logic [15:0] p_seed        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_idx_nbits-1:0] num_msgs,
  output logic                   val,
  input  logic                   rdy,
  output logic [p_msg_nbits-1:0] msg,
  output logic                   done
);

  localparam int unsigned DLY_NBITS = clog2_min1(p_max_delay + 32'd1);
  localparam logic [DLY_NBITS-1:0] DLY_RESET =
    DLY_NBITS'(32'(p_seed) % (p_max_delay + 32'd1));
  localparam logic [DLY_NBITS-1:0]   DLY_ONE = DLY_NBITS'(1'b1);
  localparam logic [p_idx_nbits-1:0] IDX_ONE = p_idx_nbits'(1'b1);
  localparam logic [p_tag_nbits-1:0] TAG_ONE = p_tag_nbits'(1'b1);

  logic [p_msg_nbits-1:0] m [p_num_entries];

  state_e                 state_r;
  state_e                 state_n;
  state_e                 cur_state_s;
  logic [p_idx_nbits-1:0] idx_r;
  logic [p_idx_nbits-1:0] idx_n;
  logic [p_idx_nbits-1:0] idx_inc_s;
  logic [p_tag_nbits-1:0] tag_r;
  logic [p_tag_nbits-1:0] tag_n;
  logic [DLY_NBITS-1:0]   dly_r;
  logic [DLY_NBITS-1:0]   dly_n;
  logic [DLY_NBITS-1:0]   dly_load_s;
  logic [15:0]            lfsr_next_s;
  logic                   xfer_s;
  logic [p_msg_nbits-1:0] msg_tagged_s;

  vc_test_lfsr16 #(
    .p_seed (p_seed)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .adv        (xfer_s),
    .next_value (lfsr_next_s)
  );

  assign idx_inc_s  = idx_r + IDX_ONE;
  assign dly_load_s = DLY_NBITS'(32'(lfsr_next_s) % (p_max_delay + 32'd1));
  assign xfer_s     = (cur_state_s == SEND) && rdy;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= DELAY;
      idx_r   <= '0;
      tag_r   <= '0;
      dly_r   <= DLY_RESET;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      tag_r   <= tag_n;
      dly_r   <= dly_n;
    end
  end

  // DELAY resolves to its successor within the same cycle, so an expired
  // delay (or an exhausted message list) costs no extra cycle.
  always_comb begin
    cur_state_s = state_r;
    if (state_r == DELAY) begin
      if (idx_r >= num_msgs) begin
        cur_state_s = DONE;
      end else if (dly_r == '0) begin
        cur_state_s = SEND;
      end else begin
        cur_state_s = DELAY;
      end
    end else begin
      cur_state_s = state_r;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    tag_n   = tag_r;
    dly_n   = dly_r;
    case (cur_state_s)
      DELAY: begin
        state_n = DELAY;
        dly_n   = dly_r - DLY_ONE;
      end
      SEND: begin
        if (rdy) begin
          idx_n = idx_inc_s;
          tag_n = tag_r + TAG_ONE;
          dly_n = dly_load_s;
          if (idx_inc_s == num_msgs) begin
            state_n = DONE;
          end else begin
            state_n = DELAY;
          end
        end else begin
          state_n = SEND;
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = DELAY;
      end
    endcase
  end

  // Outputs: decodes of registered state only; reset forces them low at once
  always_comb begin
    msg_tagged_s = m[idx_r];
    msg_tagged_s[p_tag_offset +: p_tag_nbits] = tag_r;
    if (reset && (cur_state_s == SEND)) begin
      val = 1'b1;
      msg = msg_tagged_s;
    end else begin
      val = 1'b0;
      msg = '0;
    end
    done = (state_r == DONE);
  end

endmodule

// File: tb/tb_vc_test_rand_delay_tag_source.sv
// Bench for vc_test_rand_delay_tag_source: two instances share stimulus,
// one with no idle gaps (tag at bit 0) and one with gaps up to 3 cycles
// (tag at bit 3). Expected messages and gaps are pushed into per-instance
// scoreboards when a run starts; a negedge monitor pops and compares.
module tb_vc_test_rand_delay_tag_source;

  localparam int NENT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] num_msgs = 4'd0;
  logic [1:0] val_w;
  logic [1:0] done_w;
  logic [7:0] msg_w [2];

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_img [NENT];
  logic [7:0] exp_msg [2][64];
  int         exp_gap [2][64];
  int         head [2];
  int         tail [2];

  int         xfer_cnt [2];
  int         low_cnt [2];
  int         since_rel [2];
  bit         held [2];
  logic [7:0] held_msg [2];

  always #5 clk = ~clk;

  vc_test_rand_delay_tag_source #(
    .p_msg_nbits(8), .p_num_entries(NENT), .p_idx_nbits(4),
    .p_tag_nbits(2), .p_tag_offset(0), .p_max_delay(0), .p_seed(16'hACE1)
  ) u_d0 (
    .clk(clk), .reset(reset), .num_msgs(num_msgs), .val(val_w[0]),
    .rdy(rdy), .msg(msg_w[0]), .done(done_w[0])
  );

  vc_test_rand_delay_tag_source #(
    .p_msg_nbits(8), .p_num_entries(NENT), .p_idx_nbits(4),
    .p_tag_nbits(2), .p_tag_offset(3), .p_max_delay(3), .p_seed(16'hACE1)
  ) u_d3 (
    .clk(clk), .reset(reset), .num_msgs(num_msgs), .val(val_w[1]),
    .rdy(rdy), .msg(msg_w[1]), .done(done_w[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11, shifting right
  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    logic [15:0] b;
    b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  function automatic logic [7:0] with_tag(input logic [7:0] raw, input int k, input int off);
    int v;
    v = int'(raw);
    v = v & ~(3 << off);
    v = v | ((k % 4) << off);
    return 8'(v);
  endfunction

  // Load memories and push the expected stream (reset must be low)
  task automatic prepare(input int n);
    logic [15:0] l;
    num_msgs = 4'(n);
    for (int i = 0; i < NENT; i++) begin
      u_d0.m[i] = mem_img[i];
      u_d3.m[i] = mem_img[i];
    end
    l = 16'hACE1;
    for (int k = 0; k < n; k++) begin
      exp_msg[0][k] = with_tag(mem_img[k], k, 0);
      exp_msg[1][k] = with_tag(mem_img[k], k, 3);
      exp_gap[0][k] = 0;
      exp_gap[1][k] = int'(l % 16'd4);
      l = ref_lfsr(l);
    end
    for (int d = 0; d < 2; d++) begin
      head[d] = 0;
      tail[d] = n;
    end
    rdy = 1'b1;
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic drop_rst();
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // mode 0: rdy high; 1: random rdy; 2: rdy low for 5 cycles after first transfer
  task automatic run_until_done(input int mode, input int bound);
    int zeros;
    bit ok;
    zeros = 0;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      #1;
      if (done_w == 2'b11) begin
        ok = 1'b1;
        break;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 9) < 7);
        default: begin
          if (xfer_cnt[0] >= 1 && zeros < 5) begin
            rdy = 1'b0;
            zeros++;
          end else begin
            rdy = 1'b1;
          end
        end
      endcase
    end
    chk("done_timeout", 2, 32'(ok), 32'd1);
    for (int d = 0; d < 2; d++) chk("drained", d, 32'(head[d]), 32'(tail[d]));
  endtask

  // Monitor: compare every presented transfer against the scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        chk("rst_val", d, 32'(val_w[d]), 32'd0);
        chk("rst_done", d, 32'(done_w[d]), 32'd0);
        chk("rst_msg", d, 32'(msg_w[d]), 32'd0);
        xfer_cnt[d] = 0;
        low_cnt[d] = 0;
        since_rel[d] = 0;
        held[d] = 1'b0;
      end else begin
        chk("done", d, 32'(done_w[d]),
            32'((xfer_cnt[d] == int'(num_msgs)) && (since_rel[d] >= 1)));
        if (xfer_cnt[d] == int'(num_msgs)) chk("val_idle", d, 32'(val_w[d]), 32'd0);
        if (held[d]) begin
          chk("hold_val", d, 32'(val_w[d]), 32'd1);
          chk("hold_msg", d, 32'(msg_w[d]), 32'(held_msg[d]));
        end
        if (val_w[d]) begin
          if (rdy) begin
            if (head[d] == tail[d]) begin
              chk("unexpected_msg", d, 32'(msg_w[d]), 32'hFFFF_FFFF);
            end else begin
              chk("msg", d, 32'(msg_w[d]), 32'(exp_msg[d][head[d]]));
              chk("gap", d, 32'(low_cnt[d]), 32'(exp_gap[d][head[d]]));
              head[d] = head[d] + 1;
            end
            xfer_cnt[d] = xfer_cnt[d] + 1;
            low_cnt[d] = 0;
            held[d] = 1'b0;
          end else begin
            held[d] = 1'b1;
            held_msg[d] = msg_w[d];
          end
        end else begin
          low_cnt[d] = low_cnt[d] + 1;
          held[d] = 1'b0;
        end
        since_rel[d] = since_rel[d] + 1;
      end
    end
  end

  initial begin
    bit hit;
    repeat (2) @(posedge clk);

    // Directed: 10,20,30,40 with rdy held high
    for (int i = 0; i < NENT; i++) mem_img[i] = 8'h00;
    mem_img[0] = 8'h10; mem_img[1] = 8'h20; mem_img[2] = 8'h30; mem_img[3] = 8'h40;
    prepare(4);
    release_rst();
    run_until_done(0, 100);

    // Tag wrap over six zero messages
    drop_rst();
    for (int i = 0; i < NENT; i++) mem_img[i] = 8'h00;
    prepare(6);
    release_rst();
    run_until_done(0, 100);

    // Backpressure during message 1
    drop_rst();
    for (int i = 0; i < NENT; i++) mem_img[i] = 8'($urandom);
    prepare(4);
    release_rst();
    run_until_done(2, 100);

    // Randomized contents, lengths and ready
    for (int r = 0; r < 5; r++) begin
      drop_rst();
      for (int i = 0; i < NENT; i++) mem_img[i] = 8'($urandom);
      prepare($urandom_range(1, 12));
      release_rst();
      run_until_done(1, 300);
    end

    // Empty message list
    drop_rst();
    prepare(0);
    release_rst();
    run_until_done(0, 20);

    // Reset mid-stream after two transfers, off the clock edge
    drop_rst();
    for (int i = 0; i < NENT; i++) mem_img[i] = 8'($urandom);
    prepare(8);
    release_rst();
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt[0] >= 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("two_xfers_seen", 0, 32'(hit), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_val", 2, 32'(val_w), 32'd0);
    chk("async_done", 2, 32'(done_w), 32'd0);
    repeat (2) @(posedge clk);
    prepare(8);
    release_rst();
    run_until_done(0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
